// File: rtl/core_pkg.sv
// Shared types and constants for the multicycle RV32 sequencer.
package core_pkg;

   typedef enum logic [2:0] {
      S_BOOT,
      S_FETCH,
      S_EXEC,
      S_MEM,
      S_WB,
      S_TRAP
   } seq_state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'd0,
      CAUSE_ILLEGAL  = 2'd1,
      CAUSE_MISALIGN = 2'd2,
      CAUSE_TIMEOUT  = 2'd3
   } trap_cause_e;

   localparam logic [4:0] OP_LOAD  = 5'b00000;
   localparam logic [4:0] OP_STORE = 5'b01000;

endpackage

// File: rtl/bus_watchdog.sv
// Counts cycles a memory request waits for ack; flags expiry when the wait budget is used up.
module bus_watchdog #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_wait,
   output logic o_expired
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT);

   logic [7:0] count;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)        count <= 8'd0;
      else if (i_clear) count <= 8'd0;
      else if (i_wait)  count <= count + 8'd1;
   end

   assign o_expired = i_wait && (count == LIMIT);

endmodule

// File: rtl/core_sequencer.sv
// Multicycle FETCH/EXEC/MEM/WB sequencer: owns PC and IR, arbitrates the single memory port, retires instructions.
module core_sequencer
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   input  logic        i_mem_ack,
   input  logic [31:0] i_mem_rdata,
   output logic [31:0] o_inst,
   output logic [31:0] o_pc,
   input  logic        i_rwrite,
   input  logic        i_mwrite,
   input  logic        i_rsel,
   input  logic [31:0] i_alu_result,
   input  logic [31:0] i_store_data,
   input  logic        i_pc_load,
   input  logic [31:0] i_pc_target,
   output logic [31:0] o_load_data,
   output logic        o_rf_we,
   output logic        o_trap,
   output logic [1:0]  o_trap_cause,
   output logic [31:0] o_retired
);

   seq_state_e  state, state_nx;
   trap_cause_e cause, cause_nx;
   logic [31:0] pc, ir, alu_q, wdata_q, load_q, retired;
   logic        rwrite_q, mwrite_q, rsel_q;
   logic        req, expired, misalign, illegal;

   // req is decoded from state so an async reset drops it immediately
   assign req      = (state == S_FETCH) || (state == S_MEM);
   assign illegal  = ir[1:0] != 2'b11;
   assign misalign = i_pc_load && (i_pc_target[1:0] != 2'b00);

   bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clear   (!req),
      .i_wait    (req && !i_mem_ack),
      .o_expired (expired)
   );

   always_comb begin
      state_nx = state;
      cause_nx = CAUSE_NONE;
      case (state)
         S_BOOT:  state_nx = S_FETCH;
         S_FETCH: begin
            if (i_mem_ack) state_nx = S_EXEC;
            else if (expired) begin
               state_nx = S_TRAP;
               cause_nx = CAUSE_TIMEOUT;
            end
         end
         S_EXEC: begin
            if (illegal) begin
               state_nx = S_TRAP;
               cause_nx = CAUSE_ILLEGAL;
            end else if (i_rsel || i_mwrite) state_nx = S_MEM;
            else state_nx = S_WB;
         end
         S_MEM: begin
            if (i_mem_ack) state_nx = S_WB;
            else if (expired) begin
               state_nx = S_TRAP;
               cause_nx = CAUSE_TIMEOUT;
            end
         end
         S_WB: begin
            if (misalign) begin
               state_nx = S_TRAP;
               cause_nx = CAUSE_MISALIGN;
            end else state_nx = S_FETCH;
         end
         S_TRAP:  state_nx = S_TRAP;
         default: state_nx = S_BOOT;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= S_BOOT;
         cause <= CAUSE_NONE;
      end else begin
         state <= state_nx;
         if (state != S_TRAP && state_nx == S_TRAP) cause <= cause_nx;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pc       <= RESET_PC;
         ir       <= 32'h0;
         alu_q    <= 32'h0;
         wdata_q  <= 32'h0;
         load_q   <= 32'h0;
         retired  <= 32'h0;
         rwrite_q <= 1'b0;
         mwrite_q <= 1'b0;
         rsel_q   <= 1'b0;
      end else begin
         if (state == S_FETCH && i_mem_ack) ir <= i_mem_rdata;
         if (state == S_EXEC && !illegal) begin
            rwrite_q <= i_rwrite;
            mwrite_q <= i_mwrite;
            rsel_q   <= i_rsel;
            alu_q    <= i_alu_result;
            wdata_q  <= i_store_data;
         end
         if (state == S_MEM && i_mem_ack && rsel_q) load_q <= i_mem_rdata;
         if (state == S_WB && !misalign) begin
            pc      <= i_pc_load ? i_pc_target : pc + 32'd4;
            retired <= retired + 32'd1;
         end
      end
   end

   assign o_mem_req    = req;
   assign o_mem_we     = (state == S_MEM) && mwrite_q;
   assign o_mem_addr   = (state == S_FETCH) ? pc : ((state == S_MEM) ? alu_q : 32'h0);
   assign o_mem_wdata  = wdata_q;
   assign o_inst       = ir;
   assign o_pc         = pc;
   assign o_load_data  = load_q;
   assign o_rf_we      = (state == S_WB) && rwrite_q && !misalign;
   assign o_trap       = (state == S_TRAP);
   assign o_trap_cause = cause;
   assign o_retired    = retired;

endmodule
